// File: rtl/spi_slave_shifter.sv
// SPI slave serial engine: synchronises SCK/SS_n/MOSI, shifts WIDTH-bit words per CPOL/CPHA.
// Optional sticky transmit-underrun flag via `define SPI_SLAVE_SHIFTER_UNDERRUN_EN.
module spi_slave_shifter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cpol,
  input  logic                           cpha,
  input  logic                           sclk_in,
  input  logic                           ss_n_in,
  input  logic                           mosi_in,
  output logic                           miso_out,
  output logic                           miso_oe,
  input  logic [WIDTH-1:0]               tx_data,
  input  logic                           tx_load,
  output logic                           tx_ready,
  output logic [WIDTH-1:0]               rx_data,
  output logic                           rx_valid,
  output logic [$clog2(WIDTH+1)-1:0]     bit_count,
  output logic                           busy
`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
  ,
  output logic                           tx_underrun
`endif
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_p0;
  logic [SYNC_STAGES-1:0] ss_n_sync_p0;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic                   sclk_d_p1;
  logic                   ss_n_d_p1;

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall;
  logic lead_e, trail_e, sample_e, shift_e;
  logic start_word, in_shift, abort;
  logic sample_go, shift_go, word_done, reload;

  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-2:0] rx_sr;
  logic [WIDTH-1:0] rx_word;

  // Stage p0: synchronisers; stage p1: edge-detect history.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_p0 <= '0;
      ss_n_sync_p0 <= '1;
      mosi_sync_p0 <= '0;
      sclk_d_p1    <= 1'b0;
      ss_n_d_p1    <= 1'b1;
    end else begin
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk_in};
      ss_n_sync_p0 <= {ss_n_sync_p0[SYNC_STAGES-2:0], ss_n_in};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi_in};
      sclk_d_p1    <= sclk_s;
      ss_n_d_p1    <= ss_n_s;
    end
  end

  assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
  assign ss_n_s = ss_n_sync_p0[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d_p1;
  assign sclk_fall = ~sclk_s & sclk_d_p1;
  assign ss_fall   = ss_n_d_p1 & ~ss_n_s;

  assign lead_e   = cpol ? sclk_fall : sclk_rise;
  assign trail_e  = cpol ? sclk_rise : sclk_fall;
  assign sample_e = cpha ? trail_e : lead_e;
  assign shift_e  = cpha ? lead_e : trail_e;

  assign start_word = (state == IDLE) && enable && ss_fall;
  assign in_shift   = (state == SHIFT) && enable && !ss_n_s;
  assign abort      = (state == SHIFT) && !in_shift;
  assign sample_go  = in_shift && sample_e;
  assign shift_go   = in_shift && shift_e;
  assign word_done  = sample_go && (bit_count == CW'(WIDTH-1));
  assign reload     = start_word || word_done;

  assign rx_word = {rx_sr, mosi_s};
  assign miso_oe = (state == SHIFT) && enable;
  assign busy    = (state == SHIFT);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_word) state_next = SHIFT;
      SHIFT:   if (!in_shift)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p2: shift registers, holding register and word handshakes.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b1;
      bit_count <= '0;
      miso_out  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      if (tx_load && tx_ready) begin
        hold_reg <= tx_data;
        tx_ready <= 1'b0;
      end

      // A word start consumes the holding register as it stood before this cycle's load.
      if (reload) begin
        if (tx_ready) begin
          tx_sr <= '0;
        end else begin
          tx_sr    <= hold_reg;
          tx_ready <= 1'b1;
        end
        if (!cpha) miso_out <= tx_ready ? 1'b0 : hold_reg[WIDTH-1];
      end

      if (start_word) begin
        bit_count <= '0;
        rx_sr     <= '0;
      end

      if (abort) bit_count <= '0;

      if (sample_go) begin
        rx_sr <= rx_word[WIDTH-2:0];
        if (word_done) begin
          rx_data   <= rx_word;
          rx_valid  <= 1'b1;
          bit_count <= '0;
        end else begin
          bit_count <= bit_count + CW'(1);
        end
      end

      // With no bits sampled yet, cpha=1 presents the MSB; cpha=0 already did at load.
      if (shift_go) begin
        if (bit_count != '0) begin
          miso_out <= tx_sr[WIDTH-2];
          tx_sr    <= tx_sr << 1;
        end else if (cpha) begin
          miso_out <= tx_sr[WIDTH-1];
        end
      end
    end
  end

`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_underrun <= 1'b0;
    end else begin
      if (tx_load && tx_ready) tx_underrun <= 1'b0;
      if (reload && tx_ready)  tx_underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: bus-functional SPI master, immediate-assertion checks.
module tb_spi_slave_shifter;

  logic       clock = 1'b0;
  logic       reset, enable, cpol, cpha;
  logic       sclk_in, ss_n_in, mosi_in;
  logic       miso_out, miso_oe;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] bit_count;
  logic       busy;
`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
  logic       tx_underrun;
`endif

  spi_slave_shifter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .cpol      (cpol),
    .cpha      (cpha),
    .sclk_in   (sclk_in),
    .ss_n_in   (ss_n_in),
    .mosi_in   (mosi_in),
    .miso_out  (miso_out),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .bit_count (bit_count),
    .busy      (busy)
`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
    ,
    .tx_underrun (tx_underrun)
`endif
  );

  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rv_cnt  = 0;
  int         rv_long = 0;
  logic       rv_prev = 1'b0;
  logic [7:0] rv_hist [0:15];

  // rx_valid monitor: counts pulses, records data, flags pulses wider than one cycle.
  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      if (rv_cnt < 16) rv_hist[rv_cnt] = rx_data;
      rv_cnt++;
      if (rv_prev) rv_long++;
    end
    rv_prev = (rx_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clock);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clock);
    tx_load = 1'b0;
  endtask

  // Master side: half SCK period = 4 clocks; first toggle is the leading edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    if (!cpha) begin
      mosi_in = mo[7];
      for (int i = 0; i < nbits; i++) begin
        wait_clk(4);
        mi[7-i] = miso_out;
        sclk_in = ~sclk_in;
        wait_clk(4);
        sclk_in = ~sclk_in;
        if (i < 7) mosi_in = mo[6-i];
      end
    end else begin
      for (int i = 0; i < nbits; i++) begin
        wait_clk(4);
        sclk_in = ~sclk_in;
        mosi_in = mo[7-i];
        wait_clk(4);
        mi[7-i] = miso_out;
        sclk_in = ~sclk_in;
      end
    end
  endtask

  logic [7:0] r1, r2;

  initial begin
    reset = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0;
    sclk_in = 1'b0; ss_n_in = 1'b1; mosi_in = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0;
    wait_clk(3);
    chk("rst_miso_out", {31'd0, miso_out}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_bit_count", {28'd0, bit_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_clk(4);

    // Mode 0: slave sends A5, master sends 3C
    load_tx(8'hA5);
    chk("m0_tx_ready_loaded", {31'd0, tx_ready}, 32'd0);
    ss_n_in = 1'b0;
    wait_clk(8);
    chk("m0_tx_ready_start", {31'd0, tx_ready}, 32'd1);
    chk("m0_busy", {31'd0, busy}, 32'd1);
    chk("m0_miso_oe", {31'd0, miso_oe}, 32'd1);
    spi_bits(8'h3C, 8, r1);
    wait_clk(6);
    chk("m0_miso_word", {24'd0, r1}, 32'hA5);
    chk("m0_rv_cnt", rv_cnt, 32'd1);
    chk("m0_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("m0_bit_count", {28'd0, bit_count}, 32'd0);
    ss_n_in = 1'b1;
    wait_clk(6);
    chk("m0_idle_busy", {31'd0, busy}, 32'd0);

    // Mode 3: slave sends 81, master sends F0
    cpol = 1'b1; cpha = 1'b1; sclk_in = 1'b1;
    wait_clk(6);
    load_tx(8'h81);
    ss_n_in = 1'b0;
    wait_clk(8);
    spi_bits(8'hF0, 8, r1);
    wait_clk(6);
    chk("m3_miso_word", {24'd0, r1}, 32'h81);
    chk("m3_rv_cnt", rv_cnt, 32'd2);
    chk("m3_rx_data", {24'd0, rx_data}, 32'hF0);
    ss_n_in = 1'b1;
    wait_clk(6);

    // Back-to-back in mode 0, second tx word loaded mid first word
    cpol = 1'b0; cpha = 1'b0; sclk_in = 1'b0;
    wait_clk(6);
    load_tx(8'h11);
    ss_n_in = 1'b0;
    wait_clk(8);
    fork
      spi_bits(8'hAA, 8, r1);
      begin
        wait_clk(20);
        load_tx(8'h22);
      end
    join
    spi_bits(8'h55, 8, r2);
    wait_clk(6);
    chk("b2b_miso_w1", {24'd0, r1}, 32'h11);
    chk("b2b_miso_w2", {24'd0, r2}, 32'h22);
    chk("b2b_rv_cnt", rv_cnt, 32'd4);
    chk("b2b_rx_w1", {24'd0, rv_hist[2]}, 32'hAA);
    chk("b2b_rx_w2", {24'd0, rv_hist[3]}, 32'h55);
    chk("b2b_tx_ready", {31'd0, tx_ready}, 32'd1);
    ss_n_in = 1'b1;
    wait_clk(6);

    // Abort after 5 bits, then a full word from an empty holding register
    load_tx(8'h96);
    ss_n_in = 1'b0;
    wait_clk(8);
`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
    chk("abort_underrun_clear", {31'd0, tx_underrun}, 32'd0);
`endif
    spi_bits(8'hFF, 5, r1);
    wait_clk(2);
    chk("abort_bit_count_mid", {28'd0, bit_count}, 32'd5);
    ss_n_in = 1'b1;
    wait_clk(6);
    chk("abort_rv_cnt", rv_cnt, 32'd4);
    chk("abort_bit_count", {28'd0, bit_count}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
    ss_n_in = 1'b0;
    wait_clk(8);
    spi_bits(8'hC3, 8, r1);
    wait_clk(6);
    chk("empty_miso_word", {24'd0, r1}, 32'h00);
    chk("after_abort_rv_cnt", rv_cnt, 32'd5);
    chk("after_abort_rx_data", {24'd0, rx_data}, 32'hC3);
`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
    chk("underrun_set", {31'd0, tx_underrun}, 32'd1);
`endif
    ss_n_in = 1'b1;
    wait_clk(6);
    load_tx(8'h77);
`ifdef SPI_SLAVE_SHIFTER_UNDERRUN_EN
    chk("underrun_cleared", {31'd0, tx_underrun}, 32'd0);
`endif

    // Reset at bit 4 with a freshly loaded holding register
    ss_n_in = 1'b0;
    wait_clk(8);
    load_tx(8'h3C);
    chk("rst_mid_tx_ready_full", {31'd0, tx_ready}, 32'd0);
    spi_bits(8'hFF, 4, r1);
    wait_clk(2);
    chk("rst_mid_bit_count", {28'd0, bit_count}, 32'd4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ss_n_in = 1'b1;
    sclk_in = 1'b0;
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_mid_bit_count0", {28'd0, bit_count}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_mid_miso_out", {31'd0, miso_out}, 32'd0);
    chk("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    wait_clk(6);
    ss_n_in = 1'b0;
    wait_clk(8);
    spi_bits(8'hE7, 8, r1);
    wait_clk(6);
    chk("post_rst_miso_word", {24'd0, r1}, 32'h00);
    chk("post_rst_rv_cnt", rv_cnt, 32'd6);
    chk("post_rst_rx_data", {24'd0, rx_data}, 32'hE7);
    chk("rv_single_cycle", rv_long, 32'd0);
    ss_n_in = 1'b1;
    wait_clk(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
